bip_fetch_control: RTL

- Instruction sequencer for the BIP core.
- Owns the program counter and drives the ProgramMemory address.
- Steps a FETCH/DECODE/EXEC state machine around the memory's 1-cycle synchronous read.
- Decodes the 5-bit opcode into accumulator/ALU/data-RAM control strobes for the datapath; stops on HLT.

---
 rtl/bip_fetch_control_pkg.sv | 25 ++
 rtl/bip_fetch_control_decoder.sv | 54 +++++
 rtl/bip_fetch_control.sv | 90 +++++++++
 3 files changed

// File: rtl/bip_fetch_control_pkg.sv
// bip_fetch_control_pkg: opcodes, control encodings, FSM states and control bundle for the BIP sequencer
package bip_fetch_control_pkg;
  localparam logic [4:0] OP_HLT  = 5'd0;
  localparam logic [4:0] OP_STO  = 5'd1;
  localparam logic [4:0] OP_LD   = 5'd2;
  localparam logic [4:0] OP_LDI  = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_SUBI = 5'd7;
  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALTED} state_t;
  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
  } ctrl_t;
endpackage

// File: rtl/bip_fetch_control_decoder.sv
// bip_fetch_control_decoder: opcode + phase to datapath control bundle and sequencing flags
module bip_fetch_control_decoder
  import bip_fetch_control_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5
) (
  input  state_t                  phase_i,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  output ctrl_t                   ctrl_o,
  output logic                    needs_exec_o,
  output logic                    illegal_o,
  output logic                    hlt_o
);
  always_comb begin
    ctrl_o       = '0;
    needs_exec_o = 1'b0;
    illegal_o    = 1'b0;
    hlt_o        = 1'b0;
    if (phase_i == S_DECODE) begin
      case (opcode_i)
        OP_HLT: hlt_o = 1'b1;
        OP_STO: ctrl_o.wr_ram = 1'b1;
        OP_LD, OP_ADD, OP_SUB: begin
          ctrl_o.rd_ram = 1'b1;
          needs_exec_o  = 1'b1;
        end
        OP_LDI: begin
          ctrl_o.sel_a  = SEL_A_IMM;
          ctrl_o.wr_acc = 1'b1;
        end
        OP_ADDI, OP_SUBI: begin
          ctrl_o.sel_a  = SEL_A_ALU;
          ctrl_o.sel_b  = 1'b1;
          ctrl_o.alu_op = (opcode_i == OP_SUBI) ? ALU_SUB : ALU_ADD;
          ctrl_o.wr_acc = 1'b1;
        end
        default: illegal_o = 1'b1;
      endcase
    end else if (phase_i == S_EXEC) begin
      case (opcode_i)
        OP_LD: begin
          ctrl_o.sel_a  = SEL_A_RAM;
          ctrl_o.wr_acc = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          ctrl_o.sel_a  = SEL_A_ALU;
          ctrl_o.alu_op = (opcode_i == OP_SUB) ? ALU_SUB : ALU_ADD;
          ctrl_o.wr_acc = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/bip_fetch_control.sv
// bip_fetch_control: BIP instruction sequencer owning the PC, IR, fetch/decode/exec FSM and retire counter
module bip_fetch_control
  import bip_fetch_control_pkg::*;
#(
  parameter int                  PC_WIDTH     = 12,
  parameter int                  INSTR_WIDTH  = 16,
  parameter int                  OPCODE_WIDTH = 5,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                run,
  output logic [PC_WIDTH-1:0]                 pm_addr,
  input  logic [INSTR_WIDTH-1:0]              pm_data,
  output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] operand,
  output logic [1:0]                          sel_a,
  output logic                                sel_b,
  output logic                                alu_op,
  output logic                                wr_acc,
  output logic                                wr_ram,
  output logic                                rd_ram,
  output logic                                halted,
  output logic                                illegal,
  output logic [15:0]                         retired
);
  localparam int AW = INSTR_WIDTH - OPCODE_WIDTH;
  state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]  ir_q, ir_d;
  logic [15:0]             retired_q, retired_d;
  ctrl_t                   ctrl;
  logic                    needs_exec, hlt;
  logic                    in_dec, in_exec;
  logic [OPCODE_WIDTH-1:0] opcode;
  assign in_dec  = state_q == S_DECODE;
  assign in_exec = state_q == S_EXEC;
  // DECODE sees the fresh memory word; EXEC replays the latched one
  assign opcode  = in_exec ? ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH] : pm_data[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  bip_fetch_control_decoder #(.OPCODE_WIDTH(OPCODE_WIDTH)) u_dec (
    .phase_i      (state_q),
    .opcode_i     (opcode),
    .ctrl_o       (ctrl),
    .needs_exec_o (needs_exec),
    .illegal_o    (illegal),
    .hlt_o        (hlt)
  );
  assign pm_addr = pc_q;
  assign operand = in_dec ? pm_data[AW-1:0] : in_exec ? ir_q[AW-1:0] : '0;
  assign sel_a   = ctrl.sel_a;
  assign sel_b   = ctrl.sel_b;
  assign alu_op  = ctrl.alu_op;
  assign wr_acc  = ctrl.wr_acc;
  assign wr_ram  = ctrl.wr_ram;
  assign rd_ram  = ctrl.rd_ram;
  assign halted  = state_q == S_HALTED;
  assign retired = retired_q;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: state_d = run ? S_DECODE : S_FETCH;
      S_DECODE: begin
        ir_d      = pm_data;
        state_d   = hlt ? S_HALTED : needs_exec ? S_EXEC : S_FETCH;
        pc_d      = hlt ? pc_q : pc_q + 1'b1;
        retired_d = (hlt || needs_exec || illegal) ? retired_q : retired_q + 16'd1;
      end
      S_EXEC: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 16'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end
endmodule
